lc3_mem_access_unit: RTL and testbench
======================================

Name: lc3_mem_access_unit

Overview:
- Memory-side consumer of the LC-3 effective address produced by the address adder/mux path.
- Latches the address into MAR and runs a single memory transaction with a request/ready handshake toward memory.
  - Direct transactions serve LD/ST/LDR/STR.
  - Two-phase indirect transactions serve LDI/STI: pointer read, then the access.
- Returns read data through MDR, with a one-cycle done pulse to the control FSM.

Parameters:
- ADDR_W, 16, address width (MAR, memory address bus).
- DATA_W, 16, data width (MDR, memory data buses).
- TIMEOUT_CYCLES, 255, maximum cycles o_mem_req may stay high without i_mem_ready; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock, all state on rising edge
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  start a transaction; sampled only in IDLE
- i_addr  in  ADDR_W  effective address from the address adder
- i_write  in  1  1 = store, 0 = load
- i_indirect  in  1  1 = fetch pointer at i_addr first (LDI/STI)
- i_wdata  in  DATA_W  store data, latched into MDR at start
- i_priv  in  1  1 = supervisor, 0 = user (used only with the optional feature)
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  timeout flag, valid while o_done=1
- o_acv  out  1  access-control violation flag, valid while o_done=1
- o_mar  out  ADDR_W  current MAR
- o_mdr  out  DATA_W  current MDR; holds load result after done
- o_mem_req  out  1  memory request
- o_mem_we  out  1  write enable, qualified by o_mem_req
- o_mem_addr  out  ADDR_W  equals o_mar
- o_mem_wdata  out  DATA_W  equals o_mdr
- i_mem_ready  in  1  memory completes the current request this cycle
- i_mem_rdata  in  DATA_W  read data, valid when i_mem_ready=1

Behaviour:
- Reset values:
  - state = IDLE.
  - MAR = 0, MDR = 0.
  - Timeout counter = 0.
  - All 1-bit outputs = 0.
- Reset wins over every other event, including mid-transaction. o_mem_req is low in the cycle after reset is sampled. No output from an aborted transaction is produced.
- States: IDLE, IND, ACC, DONE. Outputs are decoded from registered state and flags.
- IDLE:
  - On i_start=1: MAR <= i_addr; MDR <= i_wdata when i_write=1; latch i_write and i_indirect; clear err/acv flags.
  - Next state is IND if i_indirect=1, else ACC.
  - i_start in any other state is ignored.
- IND:
  - o_mem_req=1, o_mem_we=0.
  - On i_mem_ready: MAR <= i_mem_rdata, counter cleared, next state ACC.
- ACC:
  - o_mem_req=1, o_mem_we = latched write.
  - On i_mem_ready: for a load, MDR <= i_mem_rdata; next state DONE.
  - For a store, MDR is unchanged.
- DONE:
  - o_done=1 for exactly one cycle, then IDLE.
  - o_busy=0 in IDLE only; a new i_start is accepted the cycle after DONE.
- Handshake:
  - o_mem_req stays high and o_mem_addr, o_mem_we and o_mem_wdata stay stable until i_mem_ready=1.
  - A request completes in the same cycle ready is seen. i_mem_ready while o_mem_req=0 is ignored.
- Latency, measured from i_start at cycle 0 with zero-wait memory:
  - Direct access: o_mem_req high in cycle 1, o_done in cycle 2.
  - Indirect access: pointer request in cycle 1, access in cycle 2, o_done in cycle 3.
  - Each wait cycle adds one cycle.
- Timeout, when TIMEOUT_CYCLES>0:
  - The counter increments each cycle o_mem_req=1 and i_mem_ready=0, and clears on every phase change.
  - When the count reaches TIMEOUT_CYCLES, the unit drops the request, sets err and goes to DONE.
  - MDR is unchanged on timeout.
  - A ready arriving in the same cycle as the limit is reached wins: normal completion, no err.
- MAR wrap: address arithmetic is not performed here. A pointer value of 16'hFFFF is used as-is.

Optional Feature:
- Macro: LC3_MEM_ACV_EN.
- With the macro:
  - In user mode (i_priv latched at start = 0), an address is a violation if it is < 16'h3000 or >= 16'hFE00.
  - The check applies to MAR on entry to IND and to MAR on entry to ACC, i.e. both the pointer address and the final address.
  - On a violation no request is issued for that phase; the unit goes directly to DONE with acv=1, MDR unchanged and no memory write.
  - Supervisor mode is never checked.
- Without the macro: i_priv is ignored, o_acv is constant 0, and no check logic is built.

Test Plan:
- Direct load: i_start, i_addr=16'h3050, i_write=0, memory ready in cycle 1 with rdata=16'hBEEF -> req cycle 1 only, o_done cycle 2, o_mdr=16'hBEEF, o_err=0.
- Direct store with 3 wait cycles: i_addr=16'h4000, i_wdata=16'h1234 -> o_mem_req held cycles 1–4 with o_mem_we=1, o_mem_addr=16'h4000 and o_mem_wdata=16'h1234 stable throughout; o_done cycle 5.
- Indirect load: i_addr=16'h3100, mem[16'h3100]=16'h5000, mem[16'h5000]=16'h00AA -> two requests (16'h3100, then 16'h5000), o_mar=16'h5000, o_mdr=16'h00AA, o_done cycle 3.
- Timeout with TIMEOUT_CYCLES=4 and ready never asserted -> req high 4 cycles then low, o_done with o_err=1, MDR unchanged.
- Reset mid-indirect (i_rst in cycle 2) plus i_start while busy -> the start is ignored; after reset o_mem_req=0, o_busy=0, o_mar=0, o_mdr=0, and no o_done is produced.
- LC3_MEM_ACV_EN, i_priv=0, i_addr=16'hFE04 load -> no o_mem_req, o_done cycle 2 with o_acv=1. Same stimulus with i_priv=1 -> normal read, o_acv=0.

Source files
------------

// File: rtl/lc3_mem_access_unit.sv
// LC-3 memory access unit: MAR/MDR, direct and indirect (pointer) transactions, req/ready handshake.
// Optional user-mode access-control check is built only when LC3_MEM_ACV_EN is defined.
module lc3_mem_access_unit #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_write,
  input  logic              i_indirect,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_priv,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_acv,
  output logic [ADDR_W-1:0] o_mar,
  output logic [DATA_W-1:0] o_mdr,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              we_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              in_phase;
  logic              phase_blocked;
  logic              timeout_hit;
  logic [ADDR_W-1:0] ptr_addr;

  assign ptr_addr = ADDR_W'(i_mem_rdata);
  assign in_phase = (state == IND) || (state == ACC);

  // The limit cycle itself still accepts ready; only a silent limit cycle times out.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && !i_mem_ready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef LC3_MEM_ACV_EN
  logic priv_q;
  logic acv_q;

  // User mode may only touch 0x3000..0xFDFF; the OS region and device page are off limits.
  function automatic logic user_violation(input logic [ADDR_W-1:0] addr);
    return (addr < ADDR_W'(16'h3000)) || (addr >= ADDR_W'(16'hFE00));
  endfunction

  assign phase_blocked = acv_q;
  assign o_acv         = (state == DONE) && acv_q;
`else
  logic unused_priv;

  assign unused_priv   = i_priv;
  assign phase_blocked = 1'b0;
  assign o_acv         = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      mar      <= '0;
      mdr      <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
`ifdef LC3_MEM_ACV_EN
      priv_q   <= 1'b0;
      acv_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            mar      <= i_addr;
            if (i_write) mdr <= i_wdata;
            we_q     <= i_write;
            err_q    <= 1'b0;
            wait_cnt <= '0;
`ifdef LC3_MEM_ACV_EN
            priv_q   <= i_priv;
            acv_q    <= !i_priv && user_violation(i_addr);
`endif
            state    <= i_indirect ? IND : ACC;
          end
        end

        IND: begin
          if (phase_blocked) begin
            state <= DONE;
          end else if (i_mem_ready) begin
            mar      <= ptr_addr;
            wait_cnt <= '0;
`ifdef LC3_MEM_ACV_EN
            acv_q    <= !priv_q && user_violation(ptr_addr);
`endif
            state    <= ACC;
          end else if (timeout_hit) begin
            err_q    <= 1'b1;
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ACC: begin
          if (phase_blocked) begin
            state <= DONE;
          end else if (i_mem_ready) begin
            if (!we_q) mdr <= i_mem_rdata;
            wait_cnt <= '0;
            state    <= DONE;
          end else if (timeout_hit) begin
            err_q    <= 1'b1;
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they are glitch-free per cycle.
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign o_err       = (state == DONE) && err_q;
  assign o_mem_req   = in_phase && !phase_blocked;
  assign o_mem_we    = (state == ACC) && !phase_blocked && we_q;
  assign o_mar       = mar;
  assign o_mdr       = mdr;
  assign o_mem_addr  = mar;
  assign o_mem_wdata = mdr;

endmodule

// File: tb/tb_lc3_mem_access_unit.sv
// Directed-vector bench for lc3_mem_access_unit (TIMEOUT_CYCLES overridden to 4).
// Cycle n is observed 1 time unit after the n-th rising edge following i_start.
module tb_lc3_mem_access_unit;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_write = 1'b0;
  logic        i_indirect = 1'b0;
  logic [15:0] i_wdata = '0;
  logic        i_priv = 1'b0;
  logic        o_busy, o_done, o_err, o_acv;
  logic [15:0] o_mar, o_mdr;
  logic        o_mem_req, o_mem_we;
  logic [15:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ready = 1'b0;
  logic [15:0] i_mem_rdata = '0;

  int checks = 0;
  int passed = 0;

  lc3_mem_access_unit #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_addr(i_addr),
    .i_write(i_write),
    .i_indirect(i_indirect),
    .i_wdata(i_wdata),
    .i_priv(i_priv),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_acv(o_acv),
    .o_mar(o_mar),
    .o_mdr(o_mdr),
    .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_busy, o_done, o_err, o_acv, o_mem_req, o_mem_we} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000",
               {o_busy, o_done, o_err, o_acv, o_mem_req, o_mem_we});
    else passed++;
    checks++;
    if ({o_mar, o_mdr} !== 32'h0)
      $display("FAIL reset_regs: got mar=%h mdr=%h expected 0000 0000", o_mar, o_mdr);
    else passed++;
    i_rst = 1'b0;
    tick();
    checks++;
    if ({o_busy, o_mem_req} !== 2'b00)
      $display("FAIL reset_idle: got busy/req=%b expected 00", {o_busy, o_mem_req});
    else passed++;
  endtask

  task automatic test_direct_load();
    i_start = 1'b1; i_addr = 16'h3050; i_write = 1'b0; i_indirect = 1'b0; i_wdata = 16'hFFFF;
    tick();  // cycle 1
    i_start = 1'b0;
    checks++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_busy, o_done} !== {1'b1, 1'b0, 16'h3050, 1'b1, 1'b0})
      $display("FAIL load_req: got req=%b we=%b addr=%h busy=%b done=%b expected 1 0 3050 1 0",
               o_mem_req, o_mem_we, o_mem_addr, o_busy, o_done);
    else passed++;
    checks++;
    if (o_mdr !== 16'h0000)
      $display("FAIL load_mdr_untouched: got %h expected 0000", o_mdr);
    else passed++;
    i_mem_ready = 1'b1; i_mem_rdata = 16'hBEEF;
    tick();  // cycle 2
    i_mem_ready = 1'b0;
    checks++;
    if ({o_done, o_err, o_mem_req, o_mdr} !== {1'b1, 1'b0, 1'b0, 16'hBEEF})
      $display("FAIL load_done: got done=%b err=%b req=%b mdr=%h expected 1 0 0 beef",
               o_done, o_err, o_mem_req, o_mdr);
    else passed++;
    tick();  // cycle 3
    checks++;
    if ({o_busy, o_done, o_mdr} !== {1'b0, 1'b0, 16'hBEEF})
      $display("FAIL load_after: got busy=%b done=%b mdr=%h expected 0 0 beef", o_busy, o_done, o_mdr);
    else passed++;
  endtask

  // Ready arrives on the 4th request cycle, exactly at the timeout limit: completion must win.
  task automatic test_store_wait();
    i_start = 1'b1; i_addr = 16'h4000; i_write = 1'b1; i_indirect = 1'b0; i_wdata = 16'h1234;
    tick();
    i_start = 1'b0; i_wdata = 16'h0000;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_done} !== {1'b1, 1'b1, 16'h4000, 16'h1234, 1'b0})
        $display("FAIL store_hold_c%0d: got req=%b we=%b addr=%h wdata=%h done=%b expected 1 1 4000 1234 0",
                 c, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_done);
      else passed++;
      i_mem_ready = (c == 4);
      i_mem_rdata = 16'hDEAD;
      tick();
    end
    i_mem_ready = 1'b0;
    checks++;
    if ({o_done, o_err, o_mem_req, o_mdr} !== {1'b1, 1'b0, 1'b0, 16'h1234})
      $display("FAIL store_done: got done=%b err=%b req=%b mdr=%h expected 1 0 0 1234",
               o_done, o_err, o_mem_req, o_mdr);
    else passed++;
    tick();
  endtask

  task automatic test_indirect_load();
    i_start = 1'b1; i_addr = 16'h3100; i_write = 1'b0; i_indirect = 1'b1;
    tick();  // cycle 1: pointer read
    i_start = 1'b0;
    checks++;
    if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 16'h3100})
      $display("FAIL ind_ptr_req: got req=%b we=%b addr=%h expected 1 0 3100", o_mem_req, o_mem_we, o_mem_addr);
    else passed++;
    i_mem_ready = 1'b1; i_mem_rdata = 16'h5000;
    tick();  // cycle 2: access
    checks++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_mar, o_done} !== {1'b1, 1'b0, 16'h5000, 16'h5000, 1'b0})
      $display("FAIL ind_acc_req: got req=%b we=%b addr=%h mar=%h done=%b expected 1 0 5000 5000 0",
               o_mem_req, o_mem_we, o_mem_addr, o_mar, o_done);
    else passed++;
    i_mem_rdata = 16'h00AA;
    tick();  // cycle 3
    i_mem_ready = 1'b0;
    checks++;
    if ({o_done, o_err, o_mar, o_mdr} !== {1'b1, 1'b0, 16'h5000, 16'h00AA})
      $display("FAIL ind_done: got done=%b err=%b mar=%h mdr=%h expected 1 0 5000 00aa",
               o_done, o_err, o_mar, o_mdr);
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    i_start = 1'b1; i_addr = 16'h3200; i_write = 1'b0; i_indirect = 1'b0;
    tick();
    i_start = 1'b0;
    i_mem_ready = 1'b0; i_mem_rdata = 16'h9999;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({o_mem_req, o_done} !== 2'b10)
        $display("FAIL timeout_req_c%0d: got req/done=%b expected 10", c, {o_mem_req, o_done});
      else passed++;
      tick();
    end
    checks++;
    if ({o_mem_req, o_done, o_err, o_mdr} !== {1'b0, 1'b1, 1'b1, 16'h00AA})
      $display("FAIL timeout_done: got req=%b done=%b err=%b mdr=%h expected 0 1 1 00aa",
               o_mem_req, o_done, o_err, o_mdr);
    else passed++;
    tick();
    checks++;
    if ({o_busy, o_done, o_err} !== 3'b000)
      $display("FAIL timeout_idle: got busy/done/err=%b expected 000", {o_busy, o_done, o_err});
    else passed++;
  endtask

  // i_start held high throughout: ignored while busy and in DONE, accepted once back in IDLE.
  task automatic test_back_to_back();
    i_start = 1'b1; i_addr = 16'h3300; i_write = 1'b0; i_indirect = 1'b0;
    tick();  // cycle 1
    checks++;
    if (o_mem_addr !== 16'h3300)
      $display("FAIL b2b_first_addr: got %h expected 3300", o_mem_addr);
    else passed++;
    i_addr = 16'h3400; i_mem_ready = 1'b1; i_mem_rdata = 16'h1111;
    tick();  // cycle 2
    i_mem_ready = 1'b0;
    checks++;
    if ({o_done, o_mar, o_mdr} !== {1'b1, 16'h3300, 16'h1111})
      $display("FAIL b2b_first_done: got done=%b mar=%h mdr=%h expected 1 3300 1111", o_done, o_mar, o_mdr);
    else passed++;
    tick();  // cycle 3
    checks++;
    if ({o_busy, o_mem_req} !== 2'b00)
      $display("FAIL b2b_idle_gap: got busy/req=%b expected 00", {o_busy, o_mem_req});
    else passed++;
    tick();  // cycle 4
    i_start = 1'b0;
    checks++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, 16'h3400})
      $display("FAIL b2b_second_req: got req=%b addr=%h expected 1 3400", o_mem_req, o_mem_addr);
    else passed++;
    i_mem_ready = 1'b1; i_mem_rdata = 16'h2222;
    tick();  // cycle 5
    i_mem_ready = 1'b0;
    checks++;
    if ({o_done, o_mdr} !== {1'b1, 16'h2222})
      $display("FAIL b2b_second_done: got done=%b mdr=%h expected 1 2222", o_done, o_mdr);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    i_start = 1'b1; i_addr = 16'h3100; i_write = 1'b0; i_indirect = 1'b1;
    tick();  // cycle 1
    i_addr = 16'h3600; i_indirect = 1'b0;
    i_mem_ready = 1'b1; i_mem_rdata = 16'h5000;
    tick();  // cycle 2
    i_mem_ready = 1'b0;
    checks++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, 16'h5000})
      $display("FAIL rstmid_busy_ignore: got req=%b addr=%h expected 1 5000", o_mem_req, o_mem_addr);
    else passed++;
    i_rst = 1'b1;
    tick();  // cycle 3
    i_rst = 1'b0; i_start = 1'b0;
    checks++;
    if ({o_mem_req, o_busy, o_mar, o_mdr} !== {1'b0, 1'b0, 16'h0000, 16'h0000})
      $display("FAIL rstmid_state: got req=%b busy=%b mar=%h mdr=%h expected 0 0 0000 0000",
               o_mem_req, o_busy, o_mar, o_mdr);
    else passed++;
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_done || o_mem_req) done_seen++;
      i_mem_ready = 1'b1;
      tick();
    end
    i_mem_ready = 1'b0;
    checks++;
    if (done_seen !== 0)
      $display("FAIL rstmid_no_done: got %0d active cycles expected 0", done_seen);
    else passed++;
  endtask

  task automatic test_priv();
`ifdef LC3_MEM_ACV_EN
    i_start = 1'b1; i_addr = 16'hFE04; i_write = 1'b0; i_indirect = 1'b0; i_priv = 1'b0;
    tick();  // cycle 1
    i_start = 1'b0;
    checks++;
    if ({o_mem_req, o_busy} !== 2'b01)
      $display("FAIL acv_no_req: got req/busy=%b expected 01", {o_mem_req, o_busy});
    else passed++;
    i_mem_ready = 1'b1; i_mem_rdata = 16'h6666;
    tick();  // cycle 2
    i_mem_ready = 1'b0;
    checks++;
    if ({o_done, o_acv, o_mem_req, o_mdr} !== {1'b1, 1'b1, 1'b0, 16'h0000})
      $display("FAIL acv_done: got done=%b acv=%b req=%b mdr=%h expected 1 1 0 0000",
               o_done, o_acv, o_mem_req, o_mdr);
    else passed++;
    tick();
`endif
    i_start = 1'b1; i_addr = 16'hFE04; i_write = 1'b0; i_indirect = 1'b0; i_priv = 1'b1;
    tick();  // cycle 1
    i_start = 1'b0;
    checks++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, 16'hFE04})
      $display("FAIL priv_req: got req=%b addr=%h expected 1 fe04", o_mem_req, o_mem_addr);
    else passed++;
    i_mem_ready = 1'b1; i_mem_rdata = 16'h7777;
    tick();  // cycle 2
    i_mem_ready = 1'b0; i_priv = 1'b0;
    checks++;
    if ({o_done, o_acv, o_err, o_mdr} !== {1'b1, 1'b0, 1'b0, 16'h7777})
      $display("FAIL priv_done: got done=%b acv=%b err=%b mdr=%h expected 1 0 0 7777",
               o_done, o_acv, o_err, o_mdr);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_direct_load();
    test_store_wait();
    test_indirect_load();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_priv();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
